// File: rtl/uart_rx_fifo.sv
// Receive-side circular FIFO behind the UART receiver. The read port is first-word-fall-through.
// Status flags are registered, and a sticky overrun flag marks any dropped byte.
module uart_rx_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int ADDR_WIDTH  = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overrun,
    input  logic                  ovr_clr
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH+1)'(AFULL_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ovr_set;
    logic [ADDR_WIDTH:0]   count_nxt;

    // A read in the same cycle frees a slot, so a full FIFO still accepts the write.
    always_comb begin
        rd_acc  = rd_en && !empty;
        wr_acc  = wr_valid && (!full || rd_en);
        ovr_set = wr_valid && full && !rd_en;
    end

    always_comb begin
        count_nxt = count;
        if (wr_acc && !rd_acc) begin
            count_nxt = count + (ADDR_WIDTH+1)'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - (ADDR_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            count       <= count_nxt;
            empty       <= (count_nxt == '0);
            full        <= (count_nxt == DEPTH_C);
            almost_full <= (count_nxt >= AFULL_C);
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // A new overrun in the same cycle as ovr_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (ovr_set) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

    always_comb begin
        rd_data = '0;
        if (!empty) begin
            rd_data = mem[rd_ptr];
        end
    end

endmodule
